ttrig_period_meter: RTL

Downstream consumer of the T-trigger output `Tt`. Detects rising edges of `Tt` in the `CLK` domain and counts them. Measures the `Tt` period in `CLK` cycles and flags a stuck (non-toggling) trigger after a programmable timeout. Feeds the result registers and status LEDs of the lab board.

---
 rtl/ttrig_period_meter.sv | 100 ++++++++++
 1 files changed

// File: rtl/ttrig_period_meter.sv
// Period meter for the T-trigger output: counts Tt rising edges, measures the Tt period in
// CLK cycles and flags a stuck trigger after TIMEOUT cycles without a rising edge.
module ttrig_period_meter #(
  parameter int unsigned W       = 16,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         Tt,
  input  logic         EN,
  input  logic         CLR,
  output logic [W-1:0] PERIOD,
  output logic         PVALID,
  output logic [W-1:0] EDGES,
  output logic         STUCK
);

  typedef enum logic [1:0] {StIdle, StMeas, StStk} state_e;

  state_e         state_q;
  logic           tt_q;
  logic [W-1:0]   cnt_q;
  logic [W-1:0]   period_q;
  logic [W-1:0]   edges_q;
  logic           pvalid_q;
  logic           stuck_q;

  logic           rise;
  logic [W:0]     cnt_inc;
  logic [W-1:0]   cnt_sat;
  logic           timeout_hit;

  assign rise        = Tt & ~tt_q;
  // One extra bit so saturation and the timeout compare see the true cnt+1.
  assign cnt_inc     = {1'b0, cnt_q} + (W+1)'(1);
  assign cnt_sat     = cnt_inc[W] ? '1 : cnt_inc[W-1:0];
  assign timeout_hit = (cnt_inc == (W+1)'(TIMEOUT));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= StIdle;
      tt_q     <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      edges_q  <= '0;
      pvalid_q <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      tt_q     <= Tt;
      pvalid_q <= 1'b0;
      if (CLR) begin
        state_q  <= StIdle;
        cnt_q    <= '0;
        period_q <= '0;
        edges_q  <= '0;
        stuck_q  <= 1'b0;
      end else if (!EN) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        stuck_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StMeas: begin
            if (rise) begin
              if (state_q == StMeas) begin
                period_q <= cnt_sat;
                pvalid_q <= 1'b1;
              end
              state_q <= StMeas;
              cnt_q   <= '0;
              edges_q <= edges_q + 1'b1;
            end else begin
              cnt_q <= cnt_sat;
              if (timeout_hit) begin
                state_q <= StStk;
                stuck_q <= 1'b1;
              end
            end
          end
          StStk: begin
            // The edge that ends a stall only re-arms; its period is not meaningful.
            if (rise) begin
              state_q <= StMeas;
              cnt_q   <= '0;
              stuck_q <= 1'b0;
              edges_q <= edges_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign PERIOD = period_q;
  assign PVALID = pvalid_q;
  assign EDGES  = edges_q;
  assign STUCK  = stuck_q;

endmodule
